ex_issue_stage: RTL and testbench
=================================

Name: ex_issue_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the execute-stage ALU.
- Captures decoded operations from decode and selects register or immediate for operand B.
- Resolves EX/MEM and MEM/WB forwarding, then presents p_ALUop, p_SHAMT, p_DoubleOp, p_Shift32, p_A and p_B to the ALU.
- Uses a valid/ready handshake with a one-entry skid buffer, so backpressure from the execute side never drops an instruction.

Parameters:
WIDTH, 64, datapath width; equals the ALU operand width.
RADDR, 5, register-specifier width.

Ports:
p_clk  input  1  clock, rising edge.
p_rst  input  1  reset, asynchronous, active-high.
p_in_valid  input  1  decode presents an instruction.
p_in_ready  output  1  stage can accept this cycle.
p_in_ALUop  input  4  ALU operation code.
p_in_SHAMT  input  5  shift amount.
p_in_DoubleOp  input  1  64-bit operation flag.
p_in_Shift32  input  1  shift-plus-32 flag.
p_in_rs, p_in_rt  input  RADDR  source specifiers.
p_in_rsVal, p_in_rtVal  input  WIDTH  register-file read data.
p_in_imm  input  WIDTH  extended immediate.
p_in_useImm  input  1  B operand is the immediate.
p_in_rd  input  RADDR  destination specifier.
p_in_regWrite  input  1  instruction writes rd.
p_flush  input  1  squash all held instructions.
p_fwdMem_en, p_fwdMem_rd, p_fwdMem_val  input  1/RADDR/WIDTH  EX/MEM result bypass.
p_fwdWb_en, p_fwdWb_rd, p_fwdWb_val  input  1/RADDR/WIDTH  MEM/WB writeback bypass.
p_out_valid  output  1  ALU inputs are valid.
p_out_ready  input  1  execute stage consumes this cycle.
p_ALUop, p_SHAMT, p_DoubleOp, p_Shift32  output  4/5/1/1  to ALU.
p_A, p_B  output  WIDTH  ALU operands.
p_out_rd  output  RADDR  destination, passed downstream.
p_out_regWrite  output  1  gated write enable, passed downstream.

Behaviour:
- Storage: main entry M (drives the outputs) and skid entry S. Each holds all p_in_* fields and a valid bit.
- Reset: asynchronous, active-high.
  - M.valid=0 and S.valid=0, and all stored fields are 0.
  - Consequently p_out_valid=0, p_out_regWrite=0, p_A=p_B=0, p_ALUop=0, p_SHAMT=0, p_DoubleOp=0, p_Shift32=0, p_out_rd=0.
  - p_in_ready=1 once p_rst deasserts.
  - Reset mid-operation discards M and S.
- Handshake signals:
  - p_in_ready = !S.valid. It is registered, with no combinational path from p_out_ready.
  - acc = p_in_valid & p_in_ready.
  - xfer = p_out_valid & p_out_ready.
- Per-edge update when p_flush=0:
  - M empty or xfer: M <= S if S.valid, else M <= input if acc, else M.valid <= 0. If S drained, S.valid <= 0. If S was already valid, acc is necessarily 0.
  - M full and no xfer: on acc, S <= input. S never overwrites while valid.
  - Throughput is one instruction per cycle. Latency from acc to p_out_valid is 1 cycle.
- Flush: on the next edge, M.valid=0 and S.valid=0. Any input accepted in the flush cycle is dropped. p_in_ready=1 on the following cycle. Flush has priority over acc and xfer.
- Forwarding, combinational at the output from M's fields:
  - fwd(r, v) = p_fwdMem_val if p_fwdMem_en & p_fwdMem_rd==r & r!=0; else p_fwdWb_val if p_fwdWb_en & p_fwdWb_rd==r & r!=0; else v.
  - EX/MEM has priority over MEM/WB.
  - Register 0 never forwards.
- Stale-hold refresh: every edge, for each of M and S that is valid and not being replaced, if p_fwdWb_en & p_fwdWb_rd==rs & rs!=0, stored rsVal <= p_fwdWb_val. rtVal is refreshed the same way. This keeps held operands correct after writeback retires.
- Capture refresh: the same MEM/WB refresh applies to data captured on acc, which covers a register-file write in the same cycle as the read.
- Operand outputs:
  - p_A = fwd(M.rs, M.rsVal).
  - p_B = M.useImm ? M.imm : fwd(M.rt, M.rtVal).
- Other outputs:
  - p_ALUop, p_SHAMT, p_DoubleOp, p_Shift32 and p_out_rd come directly from M.
  - p_out_regWrite = M.regWrite & M.valid, so a bubble never writes.
- p_out_valid = M.valid.

Test Plan:
- Reset then single issue: acc at cycle 0 with ALUop=4'b0101, rs=3 (rsVal=10), rt=4 (rtVal=7), useImm=0, out_ready=1 -> cycle 1: p_out_valid=1, p_A=10, p_B=7; cycle 2: p_out_valid=0 and p_out_regWrite=0.
- Backpressure: out_ready=0 while issuing I0, I1, I2 -> I0 in M, I1 in S, p_in_ready=0, I2 held upstream. Raise out_ready -> order I0, I1, I2 with no loss or duplication.
- Forward priority: M.rs=5 with fwdMem(5, 0xAA) and fwdWb(5, 0xBB) both active -> p_A=0xAA. With rs=0 and both bypasses targeting reg 0 -> p_A=rsVal.
- Held refresh: M stalled with rt=6 (rtVal=1), fwdWb(6, 0x55) pulsed for one cycle -> p_B stays 0x55 after the pulse ends.
- Flush while M and S are full and p_in_valid=1 -> next cycle p_out_valid=0, p_out_regWrite=0, p_in_ready=1. No squashed instruction ever appears at the output.
- Reset asserted asynchronously mid-stall -> outputs go to 0 immediately without waiting for a clock edge, and p_in_ready=1 after deassert.

Source files
------------

// File: rtl/ex_issue_stage.sv
// ID/EX issue stage: operand select, EX/MEM and MEM/WB bypass,
// valid/ready handshake with a one-entry skid buffer.
module ex_issue_stage #(
    parameter int WIDTH = 64,
    parameter int RADDR = 5
) (
    input  logic             p_clk,
    input  logic             p_rst,
    input  logic             p_in_valid,
    output logic             p_in_ready,
    input  logic [3:0]       p_in_ALUop,
    input  logic [4:0]       p_in_SHAMT,
    input  logic             p_in_DoubleOp,
    input  logic             p_in_Shift32,
    input  logic [RADDR-1:0] p_in_rs,
    input  logic [RADDR-1:0] p_in_rt,
    input  logic [WIDTH-1:0] p_in_rsVal,
    input  logic [WIDTH-1:0] p_in_rtVal,
    input  logic [WIDTH-1:0] p_in_imm,
    input  logic             p_in_useImm,
    input  logic [RADDR-1:0] p_in_rd,
    input  logic             p_in_regWrite,
    input  logic             p_flush,
    input  logic             p_fwdMem_en,
    input  logic [RADDR-1:0] p_fwdMem_rd,
    input  logic [WIDTH-1:0] p_fwdMem_val,
    input  logic             p_fwdWb_en,
    input  logic [RADDR-1:0] p_fwdWb_rd,
    input  logic [WIDTH-1:0] p_fwdWb_val,
    output logic             p_out_valid,
    input  logic             p_out_ready,
    output logic [3:0]       p_ALUop,
    output logic [4:0]       p_SHAMT,
    output logic             p_DoubleOp,
    output logic             p_Shift32,
    output logic [WIDTH-1:0] p_A,
    output logic [WIDTH-1:0] p_B,
    output logic [RADDR-1:0] p_out_rd,
    output logic             p_out_regWrite
);

    typedef struct packed {
        logic             valid;
        logic [3:0]       alu_op;
        logic [4:0]       shamt;
        logic             dbl;
        logic             sh32;
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic [WIDTH-1:0] rs_val;
        logic [WIDTH-1:0] rt_val;
        logic [WIDTH-1:0] imm;
        logic             use_imm;
        logic [RADDR-1:0] rd;
        logic             reg_write;
    } entry_t;

    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t in_e;
    logic   acc;
    logic   xfer;

    // Writeback retiring into a held operand replaces the stale copy.
    function automatic entry_t refresh(
        input entry_t           e,
        input logic             en,
        input logic [RADDR-1:0] rd,
        input logic [WIDTH-1:0] val
    );
        entry_t r;
        r = e;
        if (e.valid && en && rd != '0) begin
            if (e.rs == rd) r.rs_val = val;
            if (e.rt == rd) r.rt_val = val;
        end
        return r;
    endfunction

    // Bypass select; EX/MEM is newer so it wins, r0 is hardwired.
    function automatic logic [WIDTH-1:0] fwd(
        input logic [RADDR-1:0] r,
        input logic [WIDTH-1:0] v,
        input logic             m_en,
        input logic [RADDR-1:0] m_rd,
        input logic [WIDTH-1:0] m_val,
        input logic             w_en,
        input logic [RADDR-1:0] w_rd,
        input logic [WIDTH-1:0] w_val
    );
        if (r == '0)
            return v;
        else if (m_en && m_rd == r)
            return m_val;
        else if (w_en && w_rd == r)
            return w_val;
        else
            return v;
    endfunction

    assign p_in_ready = ~s_q.valid;
    assign acc        = p_in_valid & p_in_ready;
    assign xfer       = m_q.valid & p_out_ready;

    // Next-state for main and skid entries; flush overrides everything.
    always_comb begin
        in_e.valid     = 1'b1;
        in_e.alu_op    = p_in_ALUop;
        in_e.shamt     = p_in_SHAMT;
        in_e.dbl       = p_in_DoubleOp;
        in_e.sh32      = p_in_Shift32;
        in_e.rs        = p_in_rs;
        in_e.rt        = p_in_rt;
        in_e.rs_val    = p_in_rsVal;
        in_e.rt_val    = p_in_rtVal;
        in_e.imm       = p_in_imm;
        in_e.use_imm   = p_in_useImm;
        in_e.rd        = p_in_rd;
        in_e.reg_write = p_in_regWrite;
        in_e = refresh(in_e, p_fwdWb_en,
                       p_fwdWb_rd, p_fwdWb_val);
        m_d = refresh(m_q, p_fwdWb_en,
                      p_fwdWb_rd, p_fwdWb_val);
        s_d = refresh(s_q, p_fwdWb_en,
                      p_fwdWb_rd, p_fwdWb_val);
        if (p_flush) begin
            m_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else if (!m_q.valid || xfer) begin
            if (s_q.valid) begin
                m_d       = s_d;
                s_d.valid = 1'b0;
            end else if (acc) begin
                m_d = in_e;
            end else begin
                m_d.valid = 1'b0;
            end
        end else if (acc) begin
            s_d = in_e;
        end
    end

    // Entry registers, cleared asynchronously.
    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    // ALU-facing outputs come straight from the main entry.
    always_comb begin
        p_out_valid    = m_q.valid;
        p_ALUop        = m_q.alu_op;
        p_SHAMT        = m_q.shamt;
        p_DoubleOp     = m_q.dbl;
        p_Shift32      = m_q.sh32;
        p_out_rd       = m_q.rd;
        p_out_regWrite = m_q.reg_write & m_q.valid;
        p_A = fwd(m_q.rs, m_q.rs_val,
                  p_fwdMem_en, p_fwdMem_rd, p_fwdMem_val,
                  p_fwdWb_en, p_fwdWb_rd, p_fwdWb_val);
        p_B = fwd(m_q.rt, m_q.rt_val,
                  p_fwdMem_en, p_fwdMem_rd, p_fwdMem_val,
                  p_fwdWb_en, p_fwdWb_rd, p_fwdWb_val);
        if (m_q.use_imm) p_B = m_q.imm;
    end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Testbench for ex_issue_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_ex_issue_stage;

    localparam int W = 64;
    localparam int R = 5;

    typedef struct packed {
        logic [3:0]   alu_op;
        logic [4:0]   shamt;
        logic         dbl;
        logic         sh32;
        logic [R-1:0] rs;
        logic [R-1:0] rt;
        logic [W-1:0] rs_val;
        logic [W-1:0] rt_val;
        logic [W-1:0] imm;
        logic         use_imm;
        logic [R-1:0] rd;
        logic         reg_write;
    } ins_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    ins_t         cur;
    logic         flush;
    logic         mem_en;
    logic [R-1:0] mem_rd;
    logic [W-1:0] mem_val;
    logic         wb_en;
    logic [R-1:0] wb_rd;
    logic [W-1:0] wb_val;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   o_alu;
    logic [4:0]   o_shamt;
    logic         o_dbl;
    logic         o_sh32;
    logic [W-1:0] o_a;
    logic [W-1:0] o_b;
    logic [R-1:0] o_rd;
    logic         o_rw;

    int checks = 0;
    int errors = 0;

    ins_t q[$];

    ex_issue_stage #(.WIDTH(W), .RADDR(R)) dut (
        .p_clk(clk),
        .p_rst(rst),
        .p_in_valid(in_valid),
        .p_in_ready(in_ready),
        .p_in_ALUop(cur.alu_op),
        .p_in_SHAMT(cur.shamt),
        .p_in_DoubleOp(cur.dbl),
        .p_in_Shift32(cur.sh32),
        .p_in_rs(cur.rs),
        .p_in_rt(cur.rt),
        .p_in_rsVal(cur.rs_val),
        .p_in_rtVal(cur.rt_val),
        .p_in_imm(cur.imm),
        .p_in_useImm(cur.use_imm),
        .p_in_rd(cur.rd),
        .p_in_regWrite(cur.reg_write),
        .p_flush(flush),
        .p_fwdMem_en(mem_en),
        .p_fwdMem_rd(mem_rd),
        .p_fwdMem_val(mem_val),
        .p_fwdWb_en(wb_en),
        .p_fwdWb_rd(wb_rd),
        .p_fwdWb_val(wb_val),
        .p_out_valid(out_valid),
        .p_out_ready(out_ready),
        .p_ALUop(o_alu),
        .p_SHAMT(o_shamt),
        .p_DoubleOp(o_dbl),
        .p_Shift32(o_sh32),
        .p_A(o_a),
        .p_B(o_b),
        .p_out_rd(o_rd),
        .p_out_regWrite(o_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ins_t mk(
        input logic [3:0]   alu,
        input logic [R-1:0] rs,
        input logic [W-1:0] rsv,
        input logic [R-1:0] rt,
        input logic [W-1:0] rtv,
        input logic [R-1:0] rd
    );
        ins_t e;
        e = '0;
        e.alu_op = alu;
        e.rs = rs;
        e.rs_val = rsv;
        e.rt = rt;
        e.rt_val = rtv;
        e.rd = rd;
        e.reg_write = 1'b1;
        return e;
    endfunction

    function automatic ins_t rnd();
        ins_t e;
        e.alu_op = 4'($urandom);
        e.shamt = 5'($urandom);
        e.dbl = 1'($urandom);
        e.sh32 = 1'($urandom);
        e.rs = R'($urandom_range(0, 3));
        e.rt = R'($urandom_range(0, 3));
        e.rs_val = {$urandom, $urandom};
        e.rt_val = {$urandom, $urandom};
        e.imm = {$urandom, $urandom};
        e.use_imm = 1'($urandom);
        e.rd = R'($urandom);
        e.reg_write = 1'($urandom);
        return e;
    endfunction

    // Value an ALU should see for register r holding v right now.
    function automatic logic [W-1:0] see(
        input logic [R-1:0] r,
        input logic [W-1:0] v
    );
        if (r != 0 && mem_en && mem_rd == r) return mem_val;
        if (r != 0 && wb_en && wb_rd == r) return wb_val;
        return v;
    endfunction

    // One clock: the model is a FIFO of up to two held instructions.
    task automatic tick();
        bit rdy, acc, xf;
        rdy = (q.size() < 2);
        acc = in_valid && rdy;
        xf = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (xf) void'(q.pop_front());
            if (acc) q.push_back(cur);
            foreach (q[i]) begin
                if (wb_en && wb_rd != 0) begin
                    if (q[i].rs == wb_rd) q[i].rs_val = wb_val;
                    if (q[i].rt == wb_rd) q[i].rt_val = wb_val;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        in_valid = 0;
        flush = 0;
        mem_en = 0;
        wb_en = 0;
        out_ready = 0;
    endtask

    task automatic drain();
        idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        idle();
        cur = '0;
        rst = 1;
        #2;
        checks++;
        if (out_valid !== 0 || o_rw !== 0) begin
            errors++;
            $display("FAIL reset_valid: got %b/%b want 0/0",
                     out_valid, o_rw);
        end
        checks++;
        if (o_a !== 0 || o_b !== 0) begin
            errors++;
            $display("FAIL reset_ab: got %0h/%0h want 0/0",
                     o_a, o_b);
        end
        checks++;
        if (o_alu !== 0 || o_shamt !== 0 || o_dbl !== 0 ||
            o_sh32 !== 0 || o_rd !== 0) begin
            errors++;
            $display("FAIL reset_ctl: got %h %h %b %b %h want 0",
                     o_alu, o_shamt, o_dbl, o_sh32, o_rd);
        end
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        q.delete();
        checks++;
        if (in_ready !== 1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        idle();
        out_ready = 1;
        cur = mk(4'b0101, 3, 10, 4, 7, 9);
        in_valid = 1;
        #1;
        tick();
        in_valid = 0;
        #1;
        checks++;
        if (out_valid !== 1 || o_a !== 10 || o_b !== 7 ||
            o_alu !== 4'b0101) begin
            errors++;
            $display("FAIL single_issue: got v%b A%0d B%0d op%h want v1 A10 B7 op5",
                     out_valid, o_a, o_b, o_alu);
        end
        tick();
        checks++;
        if (out_valid !== 0 || o_rw !== 0) begin
            errors++;
            $display("FAIL single_bubble: got v%b rw%b want 0/0",
                     out_valid, o_rw);
        end
    endtask

    task automatic test_backpressure();
        logic [R-1:0] seen[$];
        drain();
        cur = mk(1, 1, 1, 1, 1, 1);
        in_valid = 1;
        #1;
        tick();
        cur = mk(2, 1, 1, 1, 1, 2);
        #1;
        tick();
        cur = mk(3, 1, 1, 1, 1, 3);
        #1;
        checks++;
        if (in_ready !== 0 || o_rd !== 1 || out_valid !== 1) begin
            errors++;
            $display("FAIL bp_stall: got rdy%b rd%0d v%b want rdy0 rd1 v1",
                     in_ready, o_rd, out_valid);
        end
        tick();
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (out_valid) seen.push_back(o_rd);
            tick();
            if (q.size() == 0 && in_valid == 0) break;
            if (cur.rd == 3 && dut.m_q.valid && o_rd == 3)
                in_valid = 0;
        end
        checks++;
        if (seen.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d want 3", seen.size());
        end else begin
            checks++;
            if (seen[0] !== 1 || seen[1] !== 2 || seen[2] !== 3) begin
                errors++;
                $display("FAIL bp_order: got %0d %0d %0d want 1 2 3",
                         seen[0], seen[1], seen[2]);
            end
        end
        in_valid = 0;
    endtask

    task automatic test_fwd_priority();
        drain();
        cur = mk(0, 5, 1, 0, 0, 0);
        in_valid = 1;
        #1;
        tick();
        in_valid = 0;
        mem_en = 1; mem_rd = 5; mem_val = 64'hAA;
        wb_en = 1; wb_rd = 5; wb_val = 64'hBB;
        #1;
        checks++;
        if (o_a !== 64'hAA) begin
            errors++;
            $display("FAIL fwd_mem_first: got %0h want aa", o_a);
        end
        mem_en = 0;
        #1;
        checks++;
        if (o_a !== 64'hBB) begin
            errors++;
            $display("FAIL fwd_wb: got %0h want bb", o_a);
        end
        wb_en = 0;
        drain();
        cur = mk(0, 0, 64'h33, 0, 64'h44, 0);
        in_valid = 1;
        #1;
        tick();
        in_valid = 0;
        mem_en = 1; mem_rd = 0; mem_val = 64'hAA;
        wb_en = 1; wb_rd = 0; wb_val = 64'hBB;
        #1;
        checks++;
        if (o_a !== 64'h33 || o_b !== 64'h44) begin
            errors++;
            $display("FAIL fwd_r0: got %0h/%0h want 33/44", o_a, o_b);
        end
        idle();
    endtask

    task automatic test_held_refresh();
        drain();
        cur = mk(0, 0, 0, 6, 1, 0);
        in_valid = 1;
        #1;
        tick();
        in_valid = 0;
        wb_en = 1; wb_rd = 6; wb_val = 64'h55;
        #1;
        checks++;
        if (o_b !== 64'h55) begin
            errors++;
            $display("FAIL refresh_pulse: got %0h want 55", o_b);
        end
        tick();
        wb_en = 0;
        tick();
        checks++;
        if (o_b !== 64'h55 || out_valid !== 1) begin
            errors++;
            $display("FAIL refresh_hold: got %0h v%b want 55 v1",
                     o_b, out_valid);
        end
    endtask

    task automatic test_flush();
        int leaks = 0;
        drain();
        in_valid = 1;
        cur = mk(1, 1, 1, 1, 1, 1);
        #1;
        tick();
        tick();
        flush = 1;
        #1;
        tick();
        flush = 0;
        in_valid = 0;
        #1;
        checks++;
        if (out_valid !== 0 || o_rw !== 0 || in_ready !== 1) begin
            errors++;
            $display("FAIL flush_clear: got v%b rw%b rdy%b want 0 0 1",
                     out_valid, o_rw, in_ready);
        end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid !== 0) leaks++;
        end
        checks++;
        if (leaks != 0) begin
            errors++;
            $display("FAIL flush_leak: got %0d want 0", leaks);
        end
    endtask

    task automatic test_async_reset();
        drain();
        in_valid = 1;
        cur = mk(7, 2, 64'h99, 3, 64'h98, 4);
        cur.use_imm = 1;
        cur.imm = 64'h1234;
        #1;
        tick();
        tick();
        #1;
        rst = 1;
        #1;
        checks++;
        if (out_valid !== 0 || o_rw !== 0 || o_a !== 0 ||
            o_b !== 0 || o_alu !== 0 || o_rd !== 0) begin
            errors++;
            $display("FAIL async_reset: got v%b rw%b A%0h B%0h op%h rd%0d want 0",
                     out_valid, o_rw, o_a, o_b, o_alu, o_rd);
        end
        in_valid = 0;
        q.delete();
        #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1 || out_valid !== 0) begin
            errors++;
            $display("FAIL async_release: got rdy%b v%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 40) == 0);
            cur = rnd();
            mem_en = 1'($urandom);
            mem_rd = R'($urandom_range(0, 3));
            mem_val = {$urandom, $urandom};
            wb_en = 1'($urandom);
            wb_rd = R'($urandom_range(0, 3));
            wb_val = {$urandom, $urandom};
            #1;
            checks++;
            if (in_ready !== (q.size() < 2) ||
                out_valid !== (q.size() > 0)) begin
                errors++;
                $display("FAIL rnd_hs[%0d]: got rdy%b v%b want rdy%b v%b",
                         i, in_ready, out_valid,
                         q.size() < 2, q.size() > 0);
            end
            if (q.size() > 0) begin
                checks++;
                if (o_a !== see(q[0].rs, q[0].rs_val) ||
                    o_b !== (q[0].use_imm ? q[0].imm :
                             see(q[0].rt, q[0].rt_val))) begin
                    errors++;
                    $display("FAIL rnd_ab[%0d]: got %0h/%0h want %0h/%0h",
                             i, o_a, o_b,
                             see(q[0].rs, q[0].rs_val),
                             q[0].use_imm ? q[0].imm :
                             see(q[0].rt, q[0].rt_val));
                end
                checks++;
                if (o_alu !== q[0].alu_op ||
                    o_shamt !== q[0].shamt ||
                    o_dbl !== q[0].dbl || o_sh32 !== q[0].sh32 ||
                    o_rd !== q[0].rd || o_rw !== q[0].reg_write) begin
                    errors++;
                    $display("FAIL rnd_ctl[%0d]: got %h %h %b %b %h %b want %h %h %b %b %h %b",
                             i, o_alu, o_shamt, o_dbl, o_sh32, o_rd, o_rw,
                             q[0].alu_op, q[0].shamt, q[0].dbl,
                             q[0].sh32, q[0].rd, q[0].reg_write);
                end
            end else begin
                checks++;
                if (o_rw !== 0) begin
                    errors++;
                    $display("FAIL rnd_bubble_rw[%0d]: got %b want 0",
                             i, o_rw);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_fwd_priority();
        test_held_refresh();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
